// File: rtl/alu_exec_ctrl_pkg.sv
// Shared definitions for the ALU execute-stage sequencer.
//   - state_t      : sequencer states (IDLE / EXEC / WB_HI)
//   - OP_*         : 5-bit ALU opcode encodings; codes above OP_CPLF are undefined
//   - FLAG_*       : bit positions inside the 16-bit architectural flag register
//   - is_legal     : opcode has a defined operation
//   - uses_alu     : opcode needs the ALU (everything except LBL/LBH/MOV)
package alu_exec_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_WB_HI = 2'd2
    } state_t;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_MUL  = 5'd2;
    localparam logic [4:0] OP_DIV  = 5'd3;
    localparam logic [4:0] OP_NOT  = 5'd4;
    localparam logic [4:0] OP_AND  = 5'd5;
    localparam logic [4:0] OP_OR   = 5'd6;
    localparam logic [4:0] OP_XOR  = 5'd7;
    localparam logic [4:0] OP_INC  = 5'd8;
    localparam logic [4:0] OP_RR   = 5'd9;
    localparam logic [4:0] OP_RL   = 5'd10;
    localparam logic [4:0] OP_SETB = 5'd11;
    localparam logic [4:0] OP_CLRB = 5'd12;
    localparam logic [4:0] OP_CPLB = 5'd13;
    localparam logic [4:0] OP_LBL  = 5'd14;
    localparam logic [4:0] OP_LBH  = 5'd15;
    localparam logic [4:0] OP_MOV  = 5'd16;
    localparam logic [4:0] OP_CMP  = 5'd17;
    localparam logic [4:0] OP_SETF = 5'd18;
    localparam logic [4:0] OP_CLRF = 5'd19;
    localparam logic [4:0] OP_CPLF = 5'd20;

    localparam int FLAG_C   = 0;
    localparam int FLAG_V   = 1;
    localparam int FLAG_CMP = 2;
    localparam int FLAG_EQ  = 3;
    localparam int FLAG_IO  = 4;
    localparam int FLAG_P   = 5;
    localparam int FLAG_N   = 6;
    localparam int FLAG_Z   = 7;

    function automatic logic is_legal(input logic [4:0] opc);
        return (opc <= OP_CPLF);
    endfunction

    function automatic logic uses_alu(input logic [4:0] opc);
        return !((opc == OP_LBL) || (opc == OP_LBH) || (opc == OP_MOV));
    endfunction

endpackage

// File: rtl/alu_exec_ctrl_flags.sv
// Architectural flag register.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset (flags -> 0x0000)
//   we           : take next_in at the coming edge, otherwise hold
//   next_in      : candidate flags from the ALU
//   flags        : registered flag value
module alu_exec_ctrl_flags (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [15:0] next_in,
    output logic [15:0] flags
);

    logic [15:0] next_flags;

    always_comb begin
        next_flags = flags;
        if (we) begin
            next_flags = next_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags <= 16'h0000;
        end else begin
            flags <= next_flags;
        end
    end

endmodule

// File: rtl/alu_exec_ctrl.sv
// Execute-stage sequencer for the combinational ALU.
// Accepts one decoded op per handshake, holds it in operand latches that drive
// the ALU, owns the flag register and serialises results onto the single
// register-file write port (MUL / non-zero DIV take a second, high-half write).
// Ports:
//   clk, reset, flush                 : clock, async active-high reset, sync flush
//   in_valid/in_ready + in_*          : decoded op input handshake
//   alu_en, alu_opcode, alu_op1/2,
//   alu_bitpos, alu_imm, alu_flags    : drive the external ALU
//   alu_result_0/1, alu_next_flags    : ALU results
//   flags                             : architectural flag register
//   wb_en, wb_addr, wb_data           : register-file write port (registered)
//   illegal_op                        : one-cycle pulse for an undefined opcode
//   ops_retired                       : wrapping retired-op counter
//   fsm_state                         : current sequencer state (debug)
//
// Handshake: an op transfers at a rising edge where in_valid && in_ready and
// flush is low. in_ready depends only on state, never on in_valid; the source
// must hold its payload stable while in_valid is high and in_ready is low.
module alu_exec_ctrl
    import alu_exec_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4:0]            in_opcode,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic [15:0]           in_op1,
    input  logic [15:0]           in_op2,
    input  logic [3:0]            in_bitpos,
    input  logic [7:0]            in_imm,
    output logic                  alu_en,
    output logic [4:0]            alu_opcode,
    output logic [15:0]           alu_op1,
    output logic [15:0]           alu_op2,
    output logic [3:0]            alu_bitpos,
    output logic [7:0]            alu_imm,
    output logic [15:0]           alu_flags,
    input  logic [15:0]           alu_result_0,
    input  logic [15:0]           alu_result_1,
    input  logic [15:0]           alu_next_flags,
    output logic [15:0]           flags,
    output logic                  wb_en,
    output logic [REG_ADDR_W-1:0] wb_addr,
    output logic [15:0]           wb_data,
    output logic                  illegal_op,
    output logic [15:0]           ops_retired,
    output logic [1:0]            fsm_state
);

    // Two-result op: needs a second writeback for the high half / remainder.
    // DIV by zero produces a single 0xFFFF result, so it is not two-result.
    function automatic logic is_tr(input logic [4:0] opc, input logic [15:0] op2);
        return (opc == OP_MUL) || ((opc == OP_DIV) && (op2 != 16'h0000));
    endfunction

    function automatic logic writes_reg(input logic [4:0] opc);
        logic w;
        case (opc)
            OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_NOT, OP_AND, OP_OR, OP_XOR,
            OP_INC, OP_RR, OP_RL, OP_SETB, OP_CLRB, OP_CPLB,
            OP_LBL, OP_LBH, OP_MOV: w = 1'b1;
            default:                w = 1'b0;
        endcase
        return w;
    endfunction

    state_t                state;
    state_t                state_nxt;

    logic [4:0]            opc_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic [15:0]           op1_q;
    logic [15:0]           op2_q;
    logic [3:0]            bitpos_q;
    logic [7:0]            imm_q;
    logic [15:0]           hi_q;

    logic                  accept;
    logic                  tr_op;
    logic                  exec_end;
    logic                  wb_lo;
    logic                  wb_hi;
    logic                  retire;
    logic                  flag_we;

    // Flush squashes every effect of the current cycle: the pending write,
    // the flag update, the retire and any new accept.
    always_comb begin
        tr_op     = is_tr(opc_q, op2_q);
        in_ready  = !((state == ST_EXEC) && tr_op);
        accept    = in_valid && in_ready && !flush;
        exec_end  = (state == ST_EXEC) && !flush;
        wb_lo     = exec_end && writes_reg(opc_q);
        wb_hi     = (state == ST_WB_HI) && !flush;
        retire    = (exec_end && !tr_op) || wb_hi;
        flag_we   = exec_end && is_legal(opc_q) && uses_alu(opc_q);

        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                if (tr_op)       state_nxt = ST_WB_HI;
                else if (accept) state_nxt = ST_EXEC;
                else             state_nxt = ST_IDLE;
            end
            ST_WB_HI: begin
                if (accept) state_nxt = ST_EXEC;
                else        state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (flush) begin
            state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            opc_q    <= '0;
            rd_q     <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            bitpos_q <= '0;
            imm_q    <= '0;
        end else if (accept) begin
            opc_q    <= in_opcode;
            rd_q     <= in_rd;
            op1_q    <= in_op1;
            op2_q    <= in_op2;
            bitpos_q <= in_bitpos;
            imm_q    <= in_imm;
        end
    end

    // Writeback port, illegal pulse, high-half holding register and counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_en       <= 1'b0;
            wb_addr     <= '0;
            wb_data     <= '0;
            illegal_op  <= 1'b0;
            hi_q        <= '0;
            ops_retired <= '0;
        end else begin
            wb_en      <= 1'b0;
            illegal_op <= 1'b0;
            if (wb_lo) begin
                wb_en   <= 1'b1;
                wb_addr <= rd_q;
                wb_data <= alu_result_0;
            end else if (wb_hi) begin
                wb_en   <= 1'b1;
                wb_addr <= rd_q + REG_ADDR_W'(1);
                wb_data <= hi_q;
            end
            if (exec_end && tr_op) begin
                hi_q <= alu_result_1;
            end
            if (exec_end && !is_legal(opc_q)) begin
                illegal_op <= 1'b1;
            end
            if (retire) begin
                ops_retired <= ops_retired + 16'd1;
            end
        end
    end

    alu_exec_ctrl_flags u_flags (
        .clk     (clk),
        .reset   (reset),
        .we      (flag_we),
        .next_in (alu_next_flags),
        .flags   (flags)
    );

    assign alu_en     = uses_alu(opc_q);
    assign alu_opcode = opc_q;
    assign alu_op1    = op1_q;
    assign alu_op2    = op2_q;
    assign alu_bitpos = bitpos_q;
    assign alu_imm    = imm_q;
    assign alu_flags  = flags;
    assign fsm_state  = state;

endmodule
